// File: rtl/dm_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dm_pkg: shared types and register map for the DMI debug-module responder  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package dm_pkg;

   localparam logic [6:0] ADDR_DATA0      = 7'h04;
   localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
   localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
   localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
   localparam logic [6:0] ADDR_COMMAND    = 7'h17;

   typedef enum logic [1:0] {
      DMI_NOP   = 2'd0,
      DMI_READ  = 2'd1,
      DMI_WRITE = 2'd2,
      DMI_RSVD  = 2'd3
   } dmi_op_e;

   typedef enum logic [1:0] {
      RESP_SUCCESS = 2'd0,
      RESP_FAILED  = 2'd2,
      RESP_BUSY    = 2'd3
   } dmi_resp_e;

   typedef enum logic [2:0] {
      CMDERR_NONE       = 3'd0,
      CMDERR_BUSY       = 3'd1,
      CMDERR_NOTSUP     = 3'd2,
      CMDERR_HALTRESUME = 3'd4
   } cmderr_e;

   typedef enum logic [0:0] {
      DMI_IDLE = 1'b0,
      DMI_RESP = 1'b1
   } dmi_state_e;

   typedef enum logic [1:0] {
      A_IDLE = 2'd0,
      A_REQ  = 2'd1,
      A_WAIT = 2'd2
   } abs_state_e;

   typedef struct packed {
      logic        haltreq;
      logic        resumereq;
      logic [27:0] rsvd;
      logic        ndmreset;
      logic        dmactive;
   } dmcontrol_t;

   typedef struct packed {
      logic [2:0]  rsvd3;
      logic [4:0]  progbufsize;
      logic [10:0] rsvd2;
      logic        busy;
      logic        rsvd1;
      logic [2:0]  cmderr;
      logic [3:0]  rsvd0;
      logic [3:0]  datacount;
   } abstractcs_t;

   typedef struct packed {
      logic [7:0]  cmdtype;
      logic        rsvd;
      logic [2:0]  aarsize;
      logic        aarpostincrement;
      logic        postexec;
      logic        transfer;
      logic        write;
      logic [15:0] regno;
   } acc_cmd_t;

   function automatic logic [31:0] dmstatus_value(input logic resumeack, input logic halted);
      logic [31:0] v;
      v       = '0;
      v[17]   = resumeack;
      v[16]   = resumeack;
      v[11]   = ~halted;
      v[10]   = ~halted;
      v[9]    = halted;
      v[8]    = halted;
      v[7]    = 1'b1;
      v[3:0]  = 4'd2;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_abstract_cmd.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dm_abstract_cmd: abstract access-register FSM driving the core reg port   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module dm_abstract_cmd
   import dm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        start_i,
   input  logic        write_i,
   input  logic [15:0] regno_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        reg_req_o,
   output logic        reg_we_o,
   output logic [15:0] reg_addr_o,
   output logic [31:0] reg_wdata_o,
   input  logic        reg_gnt_i,
   input  logic        reg_rvalid_i,
   input  logic [31:0] reg_rdata_i
);

   abs_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         A_IDLE: begin
            if (start_i) begin
               state_d = A_REQ;
               we_d    = write_i;
               addr_d  = regno_i;
               wdata_d = wdata_i;
            end
         end
         A_REQ:   if (reg_gnt_i)    state_d = A_WAIT;
         A_WAIT:  if (reg_rvalid_i) state_d = A_IDLE;
         default: state_d = A_IDLE;
      endcase
      // dmactive low holds the whole access engine in reset
      if (clear_i) begin
         state_d = A_IDLE;
         we_d    = 1'b0;
         addr_d  = '0;
         wdata_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= A_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy_o      = (state_q != A_IDLE);
   assign done_o      = (state_q == A_WAIT) && reg_rvalid_i;
   assign rdata_o     = reg_rdata_i;
   assign reg_req_o   = (state_q == A_REQ);
   assign reg_we_o    = we_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: rtl/dm_dmi_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dm_dmi_responder: DMI responder with minimal RISC-V debug module          |
// | Optional macro DM_BUSY_RESP_EN: busy accesses answer op 3 instead of      |
// | raising cmderr. Rev 1.0                                                   |
// +---------------------------------------------------------------------------+
module dm_dmi_responder
   import dm_pkg::*;
#(
   parameter int DMI_ADDR_W = 7,
   parameter int DMI_DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dmi_req_valid_i,
   output logic                  dmi_req_ready_o,
   input  logic [DMI_ADDR_W-1:0] dmi_req_addr_i,
   input  logic [DMI_DATA_W-1:0] dmi_req_data_i,
   input  logic [1:0]            dmi_req_op_i,
   output logic                  dmi_resp_valid_o,
   input  logic                  dmi_resp_ready_i,
   output logic [DMI_DATA_W-1:0] dmi_resp_data_o,
   output logic [1:0]            dmi_resp_op_o,
   output logic                  halt_req_o,
   output logic                  resume_req_o,
   output logic                  ndmreset_o,
   input  logic                  halted_i,
   input  logic                  resumeack_i,
   output logic                  reg_req_o,
   output logic                  reg_we_o,
   output logic [15:0]           reg_addr_o,
   output logic [31:0]           reg_wdata_o,
   input  logic                  reg_gnt_i,
   input  logic                  reg_rvalid_i,
   input  logic [31:0]           reg_rdata_i
);

   dmi_state_e  dmi_state_q, dmi_state_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic [1:0]  resp_op_q, resp_op_d;
   logic        dmactive_q, dmactive_d;
   logic        haltreq_q, haltreq_d;
   logic        resumereq_q, resumereq_d;
   logic        ndmreset_q, ndmreset_d;
   logic        resumeack_q, resumeack_d;
   logic [31:0] data0_q, data0_d;
   logic [2:0]  cmderr_q, cmderr_d;

   logic        cmd_start;
   logic        cmd_busy;
   logic        cmd_done;
   logic [31:0] cmd_rdata;
   logic        busy_viol;

   acc_cmd_t    cmd_wr;
   dmcontrol_t  dmc_wr;
   dmcontrol_t  dmc_rd;
   abstractcs_t acs_rd;
   logic        unused_data_bits;

   assign cmd_wr = dmi_req_data_i;
   assign dmc_wr = dmi_req_data_i;
   assign unused_data_bits = ^{cmd_wr.rsvd, cmd_wr.aarpostincrement, cmd_wr.postexec,
                               dmc_wr.rsvd};

   always_comb begin
      dmc_rd          = '0;
      dmc_rd.haltreq  = haltreq_q;
      dmc_rd.ndmreset = ndmreset_q;
      dmc_rd.dmactive = dmactive_q;
      acs_rd           = '0;
      acs_rd.busy      = cmd_busy;
      acs_rd.cmderr    = cmderr_q;
      acs_rd.datacount = 4'd1;
   end

   always_comb begin
      dmi_state_d = dmi_state_q;
      resp_data_d = resp_data_q;
      resp_op_d   = resp_op_q;
      dmactive_d  = dmactive_q;
      haltreq_d   = haltreq_q;
      resumereq_d = resumereq_q;
      ndmreset_d  = ndmreset_q;
      resumeack_d = resumeack_q;
      data0_d     = data0_q;
      cmderr_d    = cmderr_q;
      cmd_start   = 1'b0;
      busy_viol   = 1'b0;

      if (resumeack_i) begin
         resumereq_d = 1'b0;
         resumeack_d = 1'b1;
      end
      if (cmd_done && !reg_we_o) data0_d = cmd_rdata;

      unique case (dmi_state_q)
         DMI_IDLE: begin
            if (dmi_req_valid_i) begin
               dmi_state_d = DMI_RESP;
               resp_data_d = '0;
               resp_op_d   = RESP_SUCCESS;
               case (dmi_req_op_i)
                  DMI_READ: begin
                     case (dmi_req_addr_i)
                        ADDR_DATA0: begin
                           if (cmd_busy) busy_viol   = 1'b1;
                           else          resp_data_d = data0_q;
                        end
                        ADDR_DMCONTROL:  resp_data_d = dmc_rd;
                        ADDR_DMSTATUS:   resp_data_d = dmstatus_value(resumeack_q, halted_i);
                        ADDR_ABSTRACTCS: resp_data_d = acs_rd;
                        default:         resp_data_d = '0;
                     endcase
                  end
                  DMI_WRITE: begin
                     case (dmi_req_addr_i)
                        ADDR_DMCONTROL: begin
                           dmactive_d = dmc_wr.dmactive;
                           haltreq_d  = dmc_wr.haltreq;
                           ndmreset_d = dmc_wr.ndmreset;
                           // haltreq wins when both are written together
                           if (dmc_wr.resumereq && !dmc_wr.haltreq) begin
                              resumereq_d = 1'b1;
                              resumeack_d = 1'b0;
                           end
                        end
                        ADDR_DATA0: begin
                           if (dmactive_q) begin
                              if (cmd_busy) busy_viol = 1'b1;
                              else          data0_d   = dmi_req_data_i;
                           end
                        end
                        ADDR_ABSTRACTCS: begin
                           if (dmactive_q) begin
                              if (cmd_busy) busy_viol = 1'b1;
                              else          cmderr_d  = cmderr_q & ~dmi_req_data_i[10:8];
                           end
                        end
                        ADDR_COMMAND: begin
                           if (dmactive_q) begin
                              if (cmd_busy) begin
                                 busy_viol = 1'b1;
                              end else if (cmderr_q == CMDERR_NONE) begin
                                 if (cmd_wr.cmdtype != 8'd0 || cmd_wr.aarsize != 3'd2)
                                    cmderr_d = CMDERR_NOTSUP;
                                 else if (!halted_i)
                                    cmderr_d = CMDERR_HALTRESUME;
                                 else if (cmd_wr.transfer)
                                    cmd_start = 1'b1;
                              end
                           end
                        end
                        default: ;
                     endcase
                  end
                  DMI_RSVD: resp_op_d = RESP_FAILED;
                  default:  ;
               endcase
               if (busy_viol) begin
`ifdef DM_BUSY_RESP_EN
                  resp_op_d = RESP_BUSY;
`else
                  if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
`endif
               end
            end
         end
         DMI_RESP: if (dmi_resp_ready_i) dmi_state_d = DMI_IDLE;
         default:  dmi_state_d = DMI_IDLE;
      endcase

      if (!dmactive_d) begin
         haltreq_d   = 1'b0;
         resumereq_d = 1'b0;
         ndmreset_d  = 1'b0;
         cmderr_d    = '0;
         data0_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dmi_state_q <= DMI_IDLE;
         resp_data_q <= '0;
         resp_op_q   <= '0;
         dmactive_q  <= 1'b0;
         haltreq_q   <= 1'b0;
         resumereq_q <= 1'b0;
         ndmreset_q  <= 1'b0;
         resumeack_q <= 1'b0;
         data0_q     <= '0;
         cmderr_q    <= '0;
      end else begin
         dmi_state_q <= dmi_state_d;
         resp_data_q <= resp_data_d;
         resp_op_q   <= resp_op_d;
         dmactive_q  <= dmactive_d;
         haltreq_q   <= haltreq_d;
         resumereq_q <= resumereq_d;
         ndmreset_q  <= ndmreset_d;
         resumeack_q <= resumeack_d;
         data0_q     <= data0_d;
         cmderr_q    <= cmderr_d;
      end
   end

   dm_abstract_cmd u_abstract_cmd (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (~dmactive_q),
      .start_i      (cmd_start),
      .write_i      (cmd_wr.write),
      .regno_i      (cmd_wr.regno),
      .wdata_i      (data0_q),
      .busy_o       (cmd_busy),
      .done_o       (cmd_done),
      .rdata_o      (cmd_rdata),
      .reg_req_o    (reg_req_o),
      .reg_we_o     (reg_we_o),
      .reg_addr_o   (reg_addr_o),
      .reg_wdata_o  (reg_wdata_o),
      .reg_gnt_i    (reg_gnt_i),
      .reg_rvalid_i (reg_rvalid_i),
      .reg_rdata_i  (reg_rdata_i)
   );

   assign dmi_req_ready_o  = (dmi_state_q == DMI_IDLE);
   assign dmi_resp_valid_o = (dmi_state_q == DMI_RESP);
   assign dmi_resp_data_o  = resp_data_q;
   assign dmi_resp_op_o    = resp_op_q;
   assign halt_req_o       = haltreq_q;
   assign resume_req_o     = resumereq_q;
   assign ndmreset_o       = ndmreset_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_dmi_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_dm_dmi_responder: directed + random bench with a behavioural DM model  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_dm_dmi_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dmi_req_valid_i;
   logic        dmi_req_ready_o;
   logic [6:0]  dmi_req_addr_i;
   logic [31:0] dmi_req_data_i;
   logic [1:0]  dmi_req_op_i;
   logic        dmi_resp_valid_o;
   logic        dmi_resp_ready_i;
   logic [31:0] dmi_resp_data_o;
   logic [1:0]  dmi_resp_op_o;
   logic        halt_req_o, resume_req_o, ndmreset_o;
   logic        halted_i, resumeack_i;
   logic        reg_req_o, reg_we_o;
   logic [15:0] reg_addr_o;
   logic [31:0] reg_wdata_o;
   logic        reg_gnt_i, reg_rvalid_i;
   logic [31:0] reg_rdata_i;

   int errors = 0;
   int checks = 0;

   // behavioural model of the debug-module state
   logic        m_dmactive, m_haltreq, m_resume, m_ndm, m_ack, m_busy, m_we;
   logic [31:0] m_data0, m_wdata;
   logic [2:0]  m_cmderr;
   logic [15:0] m_regno;

   always #5 clk = ~clk;

   dm_dmi_responder dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .dmi_req_valid_i  (dmi_req_valid_i),
      .dmi_req_ready_o  (dmi_req_ready_o),
      .dmi_req_addr_i   (dmi_req_addr_i),
      .dmi_req_data_i   (dmi_req_data_i),
      .dmi_req_op_i     (dmi_req_op_i),
      .dmi_resp_valid_o (dmi_resp_valid_o),
      .dmi_resp_ready_i (dmi_resp_ready_i),
      .dmi_resp_data_o  (dmi_resp_data_o),
      .dmi_resp_op_o    (dmi_resp_op_o),
      .halt_req_o       (halt_req_o),
      .resume_req_o     (resume_req_o),
      .ndmreset_o       (ndmreset_o),
      .halted_i         (halted_i),
      .resumeack_i      (resumeack_i),
      .reg_req_o        (reg_req_o),
      .reg_we_o         (reg_we_o),
      .reg_addr_o       (reg_addr_o),
      .reg_wdata_o      (reg_wdata_o),
      .reg_gnt_i        (reg_gnt_i),
      .reg_rvalid_i     (reg_rvalid_i),
      .reg_rdata_i      (reg_rdata_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_dmactive = 0; m_haltreq = 0; m_resume = 0; m_ndm = 0; m_ack = 0;
      m_busy = 0; m_we = 0; m_data0 = 0; m_wdata = 0; m_cmderr = 0; m_regno = 0;
   endtask

   task automatic model_access(input logic [1:0] op, input logic [6:0] addr,
                               input logic [31:0] wd,
                               output logic [31:0] ed, output logic [1:0] eo);
      logic viol;
      ed = 0; eo = 0; viol = 0;
      if (op == 2'd3) begin
         eo = 2'd2;
      end else if (op == 2'd1) begin
         if (addr == 7'h04) begin
            if (m_busy) viol = 1; else ed = m_data0;
         end else if (addr == 7'h10) begin
            ed = {m_haltreq, 1'b0, 28'h0, m_ndm, m_dmactive};
         end else if (addr == 7'h11) begin
            ed = (m_ack ? 32'h0003_0000 : 32'h0) | (halted_i ? 32'h300 : 32'hC00) | 32'h82;
         end else if (addr == 7'h16) begin
            ed = (m_busy ? 32'h1000 : 32'h0) | ({29'h0, m_cmderr} << 8) | 32'h1;
         end
      end else if (op == 2'd2) begin
         if (addr == 7'h10) begin
            m_dmactive = wd[0];
            m_haltreq  = wd[31];
            m_ndm      = wd[1];
            if (wd[30] && !wd[31]) begin m_resume = 1; m_ack = 0; end
         end else if (m_dmactive && (addr == 7'h04 || addr == 7'h16 || addr == 7'h17)) begin
            if (m_busy) viol = 1;
            else if (addr == 7'h04) m_data0 = wd;
            else if (addr == 7'h16) m_cmderr = m_cmderr & ~wd[10:8];
            else if (m_cmderr == 0) begin
               if (wd[31:24] != 0 || wd[22:20] != 3'd2) m_cmderr = 2;
               else if (!halted_i)                      m_cmderr = 4;
               else if (wd[17]) begin
                  m_busy = 1; m_we = wd[16]; m_regno = wd[15:0]; m_wdata = m_data0;
               end
            end
         end
         if (!m_dmactive) begin
            m_haltreq = 0; m_resume = 0; m_ndm = 0; m_cmderr = 0; m_data0 = 0; m_busy = 0;
         end
      end
      if (viol) begin
`ifdef DM_BUSY_RESP_EN
         eo = 2'd3;
`else
         if (m_cmderr == 0) m_cmderr = 1;
`endif
      end
   endtask

   task automatic dmi(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                      input string tag, output logic [31:0] rd, output logic [1:0] ro);
      logic [31:0] ed;
      logic [1:0]  eo;
      check({tag, ".req_ready"}, dmi_req_ready_o, 1);
      model_access(op, addr, wd, ed, eo);
      dmi_req_valid_i = 1; dmi_req_op_i = op; dmi_req_addr_i = addr; dmi_req_data_i = wd;
      tick();
      dmi_req_valid_i = 0; dmi_req_op_i = 0; dmi_req_addr_i = 0; dmi_req_data_i = 0;
      check({tag, ".resp_valid"}, dmi_resp_valid_o, 1);
      check({tag, ".ready_low"}, dmi_req_ready_o, 0);
      check({tag, ".data"}, dmi_resp_data_o, ed);
      check({tag, ".op"}, dmi_resp_op_o, eo);
      rd = dmi_resp_data_o;
      ro = dmi_resp_op_o;
      dmi_resp_ready_i = 1;
      tick();
      dmi_resp_ready_i = 0;
      check({tag, ".resp_done"}, dmi_resp_valid_o, 0);
      check({tag, ".halt_req"}, halt_req_o, m_haltreq);
      check({tag, ".resume_req"}, resume_req_o, m_resume);
      check({tag, ".ndmreset"}, ndmreset_o, m_ndm);
      check({tag, ".reg_req"}, reg_req_o, m_busy);
   endtask

   task automatic core_complete(input logic [31:0] rdata);
      check("core.req", reg_req_o, 1);
      check("core.we", reg_we_o, m_we);
      check("core.addr", reg_addr_o, m_regno);
      check("core.wdata", reg_wdata_o, m_wdata);
      reg_gnt_i = 1;
      tick();
      reg_gnt_i = 0;
      check("core.req_after_gnt", reg_req_o, 0);
      reg_rvalid_i = 1; reg_rdata_i = rdata;
      tick();
      reg_rvalid_i = 0; reg_rdata_i = 0;
      if (!m_we) m_data0 = rdata;
      m_busy = 0;
   endtask

   task automatic pulse_ack();
      resumeack_i = 1;
      tick();
      resumeack_i = 0;
      m_resume = 0; m_ack = 1;
      check("ack.resume_req", resume_req_o, 0);
   endtask

   initial begin
      logic [31:0] rd, ed;
      logic [1:0]  ro, eo;

      rst_n = 0; dmi_req_valid_i = 0; dmi_req_addr_i = 0; dmi_req_data_i = 0;
      dmi_req_op_i = 0; dmi_resp_ready_i = 0; halted_i = 0; resumeack_i = 0;
      reg_gnt_i = 0; reg_rvalid_i = 0; reg_rdata_i = 0;
      model_reset();
      repeat (3) tick();
      check("rst.req_ready", dmi_req_ready_o, 1);
      check("rst.resp_valid", dmi_resp_valid_o, 0);
      check("rst.outs", {halt_req_o, resume_req_o, ndmreset_o, reg_req_o, reg_we_o}, 0);
      check("rst.resp", {dmi_resp_op_o, dmi_resp_data_o[29:0]}, 0);
      check("rst.reg_port", {reg_addr_o, reg_wdata_o[15:0]}, 0);
      rst_n = 1;
      tick();

      dmi(2'd1, 7'h11, 0, "dmstatus0", rd, ro);
      check("dmstatus0.literal", rd, 32'h0000_0C82);

      dmi(2'd2, 7'h10, 32'h8000_0001, "haltreq", rd, ro);
      check("haltreq.out", halt_req_o, 1);
      halted_i = 1;
      dmi(2'd1, 7'h11, 0, "dmstatus_halted", rd, ro);
      check("dmstatus_halted.bits98", rd[9:8], 2'b11);

      dmi(2'd2, 7'h04, 32'hDEAD_BEEF, "wr_data0", rd, ro);
      dmi(2'd2, 7'h17, 32'h0023_1008, "cmd_write", rd, ro);
      check("cmd_write.we", reg_we_o, 1);
      check("cmd_write.addr", reg_addr_o, 16'h1008);
      check("cmd_write.wdata", reg_wdata_o, 32'hDEAD_BEEF);
      tick();
      dmi(2'd1, 7'h16, 0, "stall_acs", rd, ro);
      check("stall_acs.literal", rd, 32'h0000_1001);
      check("stall.req_held", reg_req_o, 1);
      core_complete($urandom);
      dmi(2'd1, 7'h16, 0, "acs_idle", rd, ro);
      check("acs_idle.literal", rd, 32'h0000_0001);

      dmi(2'd2, 7'h17, 32'h0022_1001, "cmd_read", rd, ro);
      core_complete(32'h1234_5678);
      dmi(2'd1, 7'h04, 0, "rd_data0", rd, ro);
      check("rd_data0.literal", rd, 32'h1234_5678);

      dmi(2'd2, 7'h17, 32'h0022_1001, "busy_start", rd, ro);
      dmi(2'd2, 7'h17, 32'h0022_1001, "busy_cmd", rd, ro);
`ifdef DM_BUSY_RESP_EN
      check("busy_cmd.op3", ro, 2'd3);
`else
      check("busy_cmd.op0", ro, 2'd0);
`endif
      core_complete(32'hCAFE_0001);
      dmi(2'd1, 7'h16, 0, "busy_acs", rd, ro);
`ifdef DM_BUSY_RESP_EN
      check("busy_acs.cmderr", rd[10:8], 3'd0);
`else
      check("busy_acs.cmderr", rd[10:8], 3'd1);
`endif
      dmi(2'd2, 7'h16, 32'h700, "clr1", rd, ro);
      dmi(2'd1, 7'h16, 0, "clr1_rd", rd, ro);
      check("clr1.cmderr", rd[10:8], 3'd0);

      halted_i = 0;
      dmi(2'd2, 7'h17, 32'h0022_1001, "notHalted", rd, ro);
      dmi(2'd1, 7'h16, 0, "notHalted_rd", rd, ro);
      check("notHalted.cmderr", rd[10:8], 3'd4);
      dmi(2'd2, 7'h16, 32'h700, "clr2", rd, ro);
      dmi(2'd2, 7'h17, 32'h0122_1001, "cmdtype1", rd, ro);
      dmi(2'd1, 7'h16, 0, "cmdtype1_rd", rd, ro);
      check("cmdtype1.cmderr", rd[10:8], 3'd2);
      dmi(2'd2, 7'h16, 32'h700, "clr3", rd, ro);
      halted_i = 1;

      // response held while the DTM stalls
      check("hold.req_ready", dmi_req_ready_o, 1);
      model_access(2'd1, 7'h11, 0, ed, eo);
      dmi_req_valid_i = 1; dmi_req_op_i = 2'd1; dmi_req_addr_i = 7'h11;
      tick();
      dmi_req_valid_i = 0; dmi_req_op_i = 0; dmi_req_addr_i = 0;
      check("hold.literal", dmi_resp_data_o, 32'h0000_0382);
      for (int i = 0; i < 5; i++) begin
         check("hold.valid", dmi_resp_valid_o, 1);
         check("hold.ready", dmi_req_ready_o, 0);
         check("hold.data", dmi_resp_data_o, ed);
         check("hold.op", dmi_resp_op_o, eo);
         tick();
      end
      dmi_resp_ready_i = 1;
      tick();
      dmi_resp_ready_i = 0;
      check("hold.released", dmi_resp_valid_o, 0);
      check("hold.ready_back", dmi_req_ready_o, 1);

      dmi(2'd2, 7'h10, 32'h4000_0001, "resumereq", rd, ro);
      check("resumereq.out", resume_req_o, 1);
      repeat (3) tick();
      check("resumereq.held", resume_req_o, 1);
      pulse_ack();
      dmi(2'd1, 7'h11, 0, "resumeack_rd", rd, ro);
      check("resumeack.bits", rd[17:16], 2'b11);
      dmi(2'd2, 7'h10, 32'hC000_0001, "halt_wins", rd, ro);
      check("halt_wins.halt", halt_req_o, 1);
      check("halt_wins.resume", resume_req_o, 0);

      for (int it = 0; it < 60; it++) begin
         logic [31:0] wd;
         logic [6:0]  a;
         wd = $urandom;
         case ($urandom_range(0, 9))
            0: dmi(2'd2, 7'h04, wd, "rnd.wr_data0", rd, ro);
            1: dmi(2'd1, 7'h04, 0, "rnd.rd_data0", rd, ro);
            2: dmi(2'd1, 7'h16, 0, "rnd.rd_acs", rd, ro);
            3: dmi(2'd2, 7'h16, wd, "rnd.wr_acs", rd, ro);
            4: dmi(2'd1, 7'h11, 0, "rnd.rd_status", rd, ro);
            5: begin
               halted_i = 1'($urandom_range(0, 1));
               case ($urandom_range(0, 4))
                  0: wd = {8'h0, 4'b0010, 4'b0010, wd[15:0]};
                  1: wd = {8'h0, 4'b0010, 4'b0011, wd[15:0]};
                  2: wd = {8'h0, 4'b0010, 4'b0000, wd[15:0]};
                  3: wd = {8'($urandom_range(1, 255)), wd[23:0]};
                  default: wd = {8'h0, 1'b0, 3'($urandom_range(3, 7)), 4'b0010, wd[15:0]};
               endcase
               dmi(2'd2, 7'h17, wd, "rnd.cmd", rd, ro);
            end
            6: begin
               a = 7'($urandom);
               if (a inside {7'h04, 7'h10, 7'h11, 7'h16, 7'h17}) a = 7'h20;
               dmi(2'($urandom_range(1, 2)), a, wd, "rnd.other", rd, ro);
            end
            7: dmi($urandom_range(0, 1) ? 2'd3 : 2'd0, 7'($urandom), wd, "rnd.nop_rsvd", rd, ro);
            8: dmi(2'd1, 7'h10, 0, "rnd.rd_dmc", rd, ro);
            default: dmi(2'd2, 7'h10, {wd[31], wd[30], 28'h0, wd[1], 1'b1}, "rnd.wr_dmc", rd, ro);
         endcase
         if (m_busy && $urandom_range(0, 2) != 0) core_complete($urandom);
         if (m_resume && $urandom_range(0, 1) == 1) pulse_ack();
      end
      if (m_busy) core_complete($urandom);

      dmi(2'd2, 7'h10, 32'h8000_0000, "deactivate", rd, ro);
      check("deactivate.halt", halt_req_o, 0);
      dmi(2'd2, 7'h04, 32'h5555_AAAA, "inactive_wr", rd, ro);
      dmi(2'd1, 7'h04, 0, "inactive_rd", rd, ro);
      check("inactive_rd.literal", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
